// File: rtl/rf_wb_arbiter.sv
// Two-requester register-file writeback arbiter with a write-pending scoreboard.
// Define WB_ARB_ROUND_ROBIN_EN for round-robin arbitration; otherwise A has fixed priority.
module rf_wb_arbiter (
  input  logic        clk,
  input  logic        reset,
  input  logic        a_valid,
  input  logic [4:0]  a_addr,
  input  logic [63:0] a_data,
  output logic        a_ready,
  input  logic        b_valid,
  input  logic [4:0]  b_addr,
  input  logic [63:0] b_data,
  output logic        b_ready,
  input  logic        issue_valid,
  input  logic [4:0]  issue_addr,
  output logic        wen,
  output logic [4:0]  wa,
  output logic [63:0] wd,
  output logic [31:0] pending
);

  logic        a_xfer;
  logic        b_xfer;
  logic        xfer;
  logic [4:0]  sel_addr;
  logic [63:0] sel_data;
  logic [31:0] clr_mask;
  logic [31:0] set_mask;

`ifdef WB_ARB_ROUND_ROBIN_EN
  // state  | meaning
  // PRIO_A | A wins when both requesters are valid
  // PRIO_B | B wins when both requesters are valid
  typedef enum logic {PRIO_A = 1'b0, PRIO_B = 1'b1} prio_t;
  prio_t prio;
  prio_t prio_next;

  always_ff @(posedge clk) begin
    if (!reset) prio <= PRIO_A;
    else        prio <= prio_next;
  end

  always_comb begin
    a_ready   = 1'b0;
    b_ready   = 1'b0;
    prio_next = prio;
    if (reset) begin
      if (a_valid && (!b_valid || prio == PRIO_A)) a_ready = 1'b1;
      else if (b_valid)                            b_ready = 1'b1;
    end
    // After any transfer the other requester gets priority.
    if (a_valid && a_ready)      prio_next = PRIO_B;
    else if (b_valid && b_ready) prio_next = PRIO_A;
  end
`else
  always_comb begin
    a_ready = reset && a_valid;
    b_ready = reset && b_valid && !a_valid;
  end
`endif

  assign a_xfer   = a_valid && a_ready;
  assign b_xfer   = b_valid && b_ready;
  assign xfer     = a_xfer || b_xfer;
  assign sel_addr = a_xfer ? a_addr : b_addr;
  assign sel_data = a_xfer ? a_data : b_data;

  always_comb begin
    clr_mask = '0;
    set_mask = '0;
    if (wen) clr_mask[wa] = 1'b1;
    if (issue_valid && issue_addr != 5'd0) set_mask[issue_addr] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      wen     <= 1'b0;
      wa      <= '0;
      wd      <= '0;
      pending <= '0;
    end else begin
      // Writes to x0 are accepted but never reach the register file.
      wen <= xfer && (sel_addr != 5'd0);
      if (xfer && sel_addr != 5'd0) begin
        wa <= sel_addr;
        wd <= sel_data;
      end
      // Set is applied after clear so a new writer wins over a same-edge commit.
      pending <= (pending & ~clr_mask) | set_mask;
    end
  end

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Directed self-checking bench for rf_wb_arbiter; expectations follow the
// WB_ARB_ROUND_ROBIN_EN setting used for the build.
module tb_rf_wb_arbiter;

  logic        clk;
  logic        reset;
  logic        a_valid;
  logic [4:0]  a_addr;
  logic [63:0] a_data;
  logic        a_ready;
  logic        b_valid;
  logic [4:0]  b_addr;
  logic [63:0] b_data;
  logic        b_ready;
  logic        issue_valid;
  logic [4:0]  issue_addr;
  logic        wen;
  logic [4:0]  wa;
  logic [63:0] wd;
  logic [31:0] pending;

  int compared;
  int mismatched;
  logic [4:0]  exp_wa;
  logic [63:0] exp_wd;
  logic        exp_a_win;

  rf_wb_arbiter dut (
    .clk(clk), .reset(reset),
    .a_valid(a_valid), .a_addr(a_addr), .a_data(a_data), .a_ready(a_ready),
    .b_valid(b_valid), .b_addr(b_addr), .b_data(b_data), .b_ready(b_ready),
    .issue_valid(issue_valid), .issue_addr(issue_addr),
    .wen(wen), .wa(wa), .wd(wd), .pending(pending)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    compared++;
    assert (observed === expected)
      else begin
        mismatched++;
        $error("FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
      end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    compared    = 0;
    mismatched  = 0;
    reset       = 1'b0;
    a_valid     = 1'b0; a_addr = '0; a_data = '0;
    b_valid     = 1'b0; b_addr = '0; b_data = '0;
    issue_valid = 1'b0; issue_addr = '0;

    // Reset held two cycles with A already requesting
    step();
    a_valid = 1'b1; a_addr = 5'd5; a_data = 64'h11;
    #1;
    check("rst_a_ready", a_ready, 1'b0);
    step();
    check("rst_wen", wen, 1'b0);
    check("rst_wa", wa, 5'd0);
    check("rst_wd", wd, 64'd0);
    check("rst_pending", pending, 32'd0);
    check("rst_b_ready", b_ready, 1'b0);

    reset = 1'b1;
    #1;
    check("first_a_ready", a_ready, 1'b1);
    step();
    a_valid = 1'b0;
    check("first_wen", wen, 1'b1);
    check("first_wa", wa, 5'd5);
    check("first_wd", wd, 64'h11);
    #1;
    check("idle_a_ready", a_ready, 1'b0);
    check("idle_b_ready", b_ready, 1'b0);

    // Lone B request; also returns round-robin priority to A
    b_valid = 1'b1; b_addr = 5'd3; b_data = 64'h33;
    #1;
    check("lone_b_ready", b_ready, 1'b1);
    check("lone_b_a_ready", a_ready, 1'b0);
    step();
    b_valid = 1'b0;
    check("lone_b_wen", wen, 1'b1);
    check("lone_b_wa", wa, 5'd3);
    check("lone_b_wd", wd, 64'h33);

    // Both valid for four cycles, back-to-back writes
    a_valid = 1'b1; a_addr = 5'd1; a_data = 64'hA1;
    b_valid = 1'b1; b_addr = 5'd2; b_data = 64'hB2;
    for (int i = 0; i < 4; i++) begin
`ifdef WB_ARB_ROUND_ROBIN_EN
      exp_a_win = (i % 2 == 0);
`else
      exp_a_win = 1'b1;
`endif
      #1;
      check($sformatf("both_a_ready_%0d", i), a_ready, exp_a_win);
      check($sformatf("both_b_ready_%0d", i), b_ready, !exp_a_win);
      step();
      exp_wa = exp_a_win ? 5'd1 : 5'd2;
      exp_wd = exp_a_win ? 64'hA1 : 64'hB2;
      check($sformatf("both_wen_%0d", i), wen, 1'b1);
      check($sformatf("both_wa_%0d", i), wa, exp_wa);
      check($sformatf("both_wd_%0d", i), wd, exp_wd);
    end
    a_valid = 1'b0; b_valid = 1'b0;
    step();
    check("hold_wen", wen, 1'b0);
    check("hold_wa", wa, exp_wa);
    check("hold_wd", wd, exp_wd);

    // Write to x0: accepted, never committed
    a_valid = 1'b1; a_addr = 5'd0; a_data = 64'hFF;
    #1;
    check("x0_a_ready", a_ready, 1'b1);
    step();
    a_valid = 1'b0;
    check("x0_wen", wen, 1'b0);
    check("x0_wa", wa, exp_wa);
    check("x0_pending", pending, 32'd0);

    // Scoreboard set, ignored x0 issue, commit clear, set-wins-over-clear
    issue_valid = 1'b1; issue_addr = 5'd7;
    step();
    check("issue7_pending", pending, 32'h80);
    issue_addr = 5'd0;
    step();
    issue_valid = 1'b0;
    check("issue0_pending", pending, 32'h80);

    a_valid = 1'b1; a_addr = 5'd7; a_data = 64'h77;
    step();
    a_valid = 1'b0;
    check("w7_wen", wen, 1'b1);
    check("w7_wa", wa, 5'd7);
    check("w7_pending_before_commit", pending, 32'h80);
    issue_valid = 1'b1; issue_addr = 5'd7;
    step();
    issue_valid = 1'b0;
    check("w7_set_wins", pending, 32'h80);
    check("w7_wen_after", wen, 1'b0);

    a_valid = 1'b1; a_addr = 5'd7; a_data = 64'h78;
    step();
    a_valid = 1'b0;
    check("w7b_wen", wen, 1'b1);
    check("w7b_wd", wd, 64'h78);
    check("w7b_pending_held", pending, 32'h80);
    step();
    check("w7b_pending_cleared", pending, 32'd0);
    check("w7b_wen_after", wen, 1'b0);

    // Reset asserted while A is being accepted
    issue_valid = 1'b1; issue_addr = 5'd9;
    step();
    issue_valid = 1'b0;
    check("issue9_pending", pending, 32'h200);
    a_valid = 1'b1; a_addr = 5'd4; a_data = 64'h44;
    #1;
    check("pre_rst_a_ready", a_ready, 1'b1);
    reset = 1'b0;
    #1;
    check("in_rst_a_ready", a_ready, 1'b0);
    step();
    check("post_rst_wen", wen, 1'b0);
    check("post_rst_pending", pending, 32'd0);
    check("post_rst_wa", wa, 5'd0);
    check("post_rst_wd", wd, 64'd0);
    check("post_rst_a_ready", a_ready, 1'b0);

    reset = 1'b1;
    step();
    a_valid = 1'b0;
    check("rel_wen", wen, 1'b1);
    check("rel_wa", wa, 5'd4);
    check("rel_wd", wd, 64'h44);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
